// File: rtl/vram_pkg.sv
// Shared constants and enums for the video RAM arbiter slice.
package vram_pkg;
  localparam int AW    = 14;
  localparam int DW    = 16;
  localparam int WORDS = 9216;

  typedef enum logic {FILL_IDLE, FILL_RUN} fill_st_e;
  typedef enum logic [2:0] {G_NONE, G_DISP, G_FILL, G_WR, G_RD} grant_e;
endpackage

// File: rtl/vram_arbiter_if.sv
// Host request/response bus of the video RAM arbiter.
interface vram_arbiter_if;
  import vram_pkg::*;

  logic          host_valid;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ready;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;

  modport master (output host_valid, host_we, host_addr, host_wdata,
                  input  host_ready, host_rvalid, host_rdata);
  modport slave  (input  host_valid, host_we, host_addr, host_wdata,
                  output host_ready, host_rvalid, host_rdata);
endinterface

// File: rtl/vram_wfifo.sv
// Host write-posting FIFO; DEPTH must be a power of two (>= 2).
module vram_wfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 30
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/vram_arbiter.sv
// Single-port framebuffer arbiter: scanout > fill engine > posted writes > host reads.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_data,
  vram_arbiter_if.slave host,
  input  logic          clr_start,
  input  logic [DW-1:0] clr_pattern,
  output logic          clr_busy,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  fill_st_e         fill_q, fill_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    pat_q;
  logic             disp_vld_q, rd_vld_q;
  grant_e           grant;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [AW+DW-1:0] fifo_din, fifo_dout;
  logic             wr_ok, rd_ok, fill_start;

  assign clr_busy = (fill_q == FILL_RUN);
  assign wr_ok    = host.host_we && !fifo_full && !clr_busy;
  // An empty FIFO before a read keeps reads ordered behind posted writes.
  assign rd_ok    = !host.host_we && fifo_empty && !clr_busy && !disp_req;
  assign host.host_ready = rst_n && host.host_valid && (wr_ok || rd_ok);

  assign fifo_push  = host.host_ready && host.host_we;
  assign fifo_din   = {host.host_addr, host.host_wdata};
  assign fifo_pop   = (grant == G_WR);
  assign fill_start = (fill_q == FILL_IDLE) && clr_start && fifo_empty;

  vram_wfifo #(.DEPTH(FIFO_DEPTH), .W(AW+DW)) u_wfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    grant = G_NONE;
    if (rst_n) begin
      if (disp_req)                     grant = G_DISP;
      else if (clr_busy)                grant = G_FILL;
      else if (!fifo_empty)             grant = G_WR;
      else if (host.host_valid && rd_ok) grant = G_RD;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (grant)
      G_DISP: ram_addr = disp_addr;
      G_FILL: begin
        ram_addr  = cnt_q;
        ram_we    = 1'b1;
        ram_wdata = pat_q;
      end
      G_WR: begin
        ram_addr  = fifo_dout[AW+DW-1:DW];
        ram_we    = 1'b1;
        ram_wdata = fifo_dout[DW-1:0];
      end
      G_RD:    ram_addr = host.host_addr;
      default: ram_addr = '0;
    endcase
  end

  always_comb begin
    fill_d = fill_q;
    cnt_d  = cnt_q;
    case (fill_q)
      FILL_IDLE: if (fill_start) begin
        fill_d = FILL_RUN;
        cnt_d  = '0;
      end
      FILL_RUN: if (grant == G_FILL) begin
        if (cnt_q == AW'(WORDS-1)) begin
          fill_d = FILL_IDLE;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
        end
      end
      default: fill_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_q     <= FILL_IDLE;
      cnt_q      <= '0;
      disp_vld_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      disp_vld_q <= (grant == G_DISP);
      rd_vld_q   <= (grant == G_RD);
    end
  end

  always_ff @(posedge clk) begin
    if (fill_start) pat_q <= clr_pattern;
  end

  assign disp_valid       = disp_vld_q;
  assign disp_data        = disp_vld_q ? ram_rdata : '0;
  assign host.host_rvalid = rd_vld_q;
  assign host.host_rdata  = rd_vld_q ? ram_rdata : '0;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: RAM model, cycle-level reference model and directed tests.
module tb_vram_arbiter;
  import vram_pkg::*;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst_n, disp_req, clr_start;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] clr_pattern;
  logic          disp_valid, clr_busy, ram_we;
  logic [DW-1:0] disp_data, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;

  vram_arbiter_if host_if();

  vram_arbiter #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_valid  (disp_valid),
    .disp_data   (disp_data),
    .host        (host_if),
    .clr_start   (clr_start),
    .clr_pattern (clr_pattern),
    .clr_busy    (clr_busy),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 16) return 16'hA5A5;
    return DW'(i ^ 16'h3C3C);
  endfunction

  // Framebuffer RAM: 1-cycle synchronous read, preloaded on the first edge
  logic [DW-1:0] mem [16384];
  bit mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference model state
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t           mq[$];
  logic [DW-1:0] gold [16384];
  bit            gold_loaded = 1'b0;
  bit            m_fill, m_dv, m_rv;
  int            m_cnt;
  logic [DW-1:0] m_pat, m_dd, m_rd;
  bit            chk_en = 1'b0;
  int            n_cmp = 0, n_bad = 0;

  function automatic bit exp_ready();
    if (!rst_n || !host_if.host_valid) return 1'b0;
    if (host_if.host_we) return (mq.size() < FIFO_DEPTH) && !m_fill;
    return (mq.size() == 0) && !m_fill && !disp_req;
  endfunction

  // 0 none, 1 scanout, 2 fill, 3 posted write, 4 host read
  function automatic int exp_grant();
    if (!rst_n)       return 0;
    if (disp_req)     return 1;
    if (m_fill)       return 2;
    if (mq.size() != 0) return 3;
    if (exp_ready() && !host_if.host_we) return 4;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    bit rdy, start;
    wr_t h;
    if (!gold_loaded) begin
      for (int i = 0; i < 16384; i++) gold[i] = init_word(i);
      gold_loaded = 1'b1;
    end
    if (!rst_n) begin
      mq.delete();
      m_fill = 1'b0; m_cnt = 0; m_dv = 1'b0; m_rv = 1'b0;
      chk_en = 1'b1;
    end else begin
      g     = exp_grant();
      rdy   = exp_ready();
      start = clr_start && !m_fill && (mq.size() == 0);
      m_dv  = (g == 1);
      if (g == 1) m_dd = gold[disp_addr];
      m_rv  = (g == 4);
      if (g == 4) m_rd = gold[host_if.host_addr];
      if (g == 2) begin
        gold[m_cnt] = m_pat;
        if (m_cnt == WORDS-1) begin m_fill = 1'b0; m_cnt = 0; end
        else m_cnt++;
      end
      if (g == 3) begin
        h = mq.pop_front();
        gold[h.a] = h.d;
      end
      if (rdy && host_if.host_we) mq.push_back({host_if.host_addr, host_if.host_wdata});
      if (start) begin m_fill = 1'b1; m_cnt = 0; m_pat = clr_pattern; end
    end
  end

  always @(negedge clk) begin
    int g;
    logic exp_we;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [66:0] e, a;
    if (chk_en) begin
      g = exp_grant();
      exp_we = (g == 2) || (g == 3);
      ea = '0; ew = '0;
      case (g)
        1: ea = disp_addr;
        2: begin ea = AW'(m_cnt); ew = m_pat; end
        3: begin ea = mq[0].a; ew = mq[0].d; end
        4: ea = host_if.host_addr;
        default: ea = '0;
      endcase
      e = {m_dv, m_dv ? m_dd : 16'h0, m_rv, m_rv ? m_rd : 16'h0,
           m_fill, exp_ready(), exp_we, ea, ew};
      a = {disp_valid, m_dv ? disp_data : 16'h0, host_if.host_rvalid,
           m_rv ? host_if.host_rdata : 16'h0, clr_busy, host_if.host_ready,
           ram_we, (g != 0) ? ram_addr : 14'h0, exp_we ? ram_wdata : 16'h0};
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_read(input logic [AW-1:0] addr, output logic [DW-1:0] d);
    bit got = 1'b0;
    host_if.host_valid = 1'b1;
    host_if.host_we    = 1'b0;
    host_if.host_addr  = addr;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (host_if.host_ready) got = 1'b1;
      step();
    end
    host_if.host_valid = 1'b0;
    chk("rd_accept", got, 1);
    @(negedge clk);
    chk("rd_rvalid", host_if.host_rvalid, 1);
    d = host_if.host_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d, wv;
    int busy_cnt, ndisp, bad;
    bit seen, done;
    rst_n = 1'b0; disp_req = 1'b0; disp_addr = '0; clr_start = 1'b0; clr_pattern = '0;
    host_if.host_valid = 1'b0; host_if.host_we = 1'b0;
    host_if.host_addr = '0; host_if.host_wdata = '0;

    // Reset with a stray clr_start
    step();
    clr_start = 1'b1; clr_pattern = 16'hFFFF;
    step();
    clr_start = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {disp_valid, host_if.host_ready, host_if.host_rvalid, clr_busy,
                          ram_we, 2'b00, ram_addr, disp_data, host_if.host_rdata,
                          ram_wdata} == '0, 1);
    step();
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    chk("no_fill_after_reset", clr_busy, 0);

    // Scanout fetch
    disp_req = 1'b1; disp_addr = 14'h0010;
    step();
    disp_req = 1'b0;
    @(negedge clk);
    chk("disp_valid", disp_valid, 1);
    chk("disp_data", disp_data, 16'hA5A5);

    // Back-to-back posted writes with scanout on cycles 1 and 2
    for (int i = 0; i < 5; i++) begin
      host_if.host_valid = 1'b1; host_if.host_we = 1'b1;
      host_if.host_addr  = AW'(i);
      host_if.host_wdata = DW'(16'h1111 * (i + 1));
      disp_req = (i == 1) || (i == 2); disp_addr = 14'h0020;
      @(negedge clk);
      chk("wr_ready_burst", host_if.host_ready, 1);
      step();
    end
    host_if.host_valid = 1'b0; disp_req = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 5; i++) begin
      wv = DW'(16'h1111 * (i + 1));
      chk("burst_ram_word", mem[i], wv);
    end

    // Read-after-write stalls until the FIFO drains
    host_if.host_valid = 1'b1; host_if.host_we = 1'b1;
    host_if.host_addr = 14'd5; host_if.host_wdata = 16'h00FF;
    @(negedge clk);
    chk("raw_wr_ready", host_if.host_ready, 1);
    step();
    host_if.host_we = 1'b0;
    @(negedge clk);
    chk("raw_rd_stall", host_if.host_ready, 0);
    step();
    host_read(14'd5, d);
    chk("raw_rd_data", d, 16'h00FF);
    step();

    // Full fill with scanout every 80 cycles and refused host writes
    clr_pattern = 16'h5555; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    busy_cnt = 0; ndisp = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < 12000 && !done; c++) begin
      disp_req  = (c % 80 == 40);
      disp_addr = AW'(c % WORDS);
      host_if.host_valid = (c >= 5 && c < 9);
      host_if.host_we = 1'b1; host_if.host_addr = 14'd7; host_if.host_wdata = 16'hBEEF;
      @(negedge clk);
      if (c >= 5 && c < 9) chk("wr_refused_in_fill", host_if.host_ready, 0);
      if (clr_busy) begin
        busy_cnt++;
        if (disp_req) ndisp++;
        seen = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
      step();
    end
    disp_req = 1'b0; host_if.host_valid = 1'b0;
    chk("fill_finished", done, 1);
    chk("fill_disp_count", ndisp, 117);
    chk("fill_busy_cycles", busy_cnt, 9333);
    bad = 0;
    for (int i = 0; i < WORDS; i++) if (mem[i] !== 16'h5555) bad++;
    chk("fill_all_words", bad, 0);
    host_read(14'd0, d);
    chk("fill_rd_first", d, 16'h5555);
    host_read(14'd9215, d);
    chk("fill_rd_last", d, 16'h5555);
    step();

    // Reset mid-fill at cnt = 100
    clr_pattern = 16'hAAAA; clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (100) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("busy_after_reset", clr_busy, 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("abort_word0", mem[0], 16'hAAAA);
    chk("abort_word99", mem[99], 16'hAAAA);
    chk("abort_word100", mem[100], 16'h5555);
    chk("abort_word9215", mem[9215], 16'h5555);
    @(negedge clk);
    chk("idle_after_abort", clr_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Arbitrates the single synchronous video RAM port (9216 x 16-bit words, 512x288 monochrome frame) among three requesters: the scanout fetch, a host CPU, and an internal clear/fill engine.
- Sits between the TV-out scanout logic and the framebuffer RAM, and runs in the 50 MHz clk domain.
- Scanout fetches always win.
- Host writes are posted through a small FIFO.
- Host reads and the fill engine use the remaining free cycles.

Parameters:
- AW, 14, RAM word address width
- DW, 16, RAM data width
- WORDS, 9216, number of framebuffer words (512*288/16)
- FIFO_DEPTH, 4, host write-posting FIFO depth (power of two)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  synchronous active-low reset
- disp_req  in  1  scanout fetch request, single-cycle pulse
- disp_addr  in  AW  scanout word address
- disp_valid  out  1  scanout data valid
- disp_data  out  DW  scanout fetched word
- host_valid  in  1  host request valid
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host word address
- host_wdata  in  DW  host write data
- host_ready  out  1  host request accepted this cycle (valid && ready)
- host_rvalid  out  1  host read data valid
- host_rdata  out  DW  host read data
- clr_start  in  1  start fill of whole framebuffer
- clr_pattern  in  DW  fill word, sampled when clr_start is accepted
- clr_busy  out  1  fill in progress
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, 1-cycle synchronous read

Behaviour:
- Reset: all outputs are 0 (disp_valid, host_ready, host_rvalid, clr_busy, ram_we, ram_addr, ram_wdata, disp_data, host_rdata). FIFO is emptied; fill state is IDLE with counter 0. Reset mid-fill aborts the fill immediately.
- RAM port grant, one access per clk, fixed priority:
  1. disp_req
  2. fill engine (clr_busy)
  3. FIFO head write (FIFO not empty)
  4. host read
- RAM port outputs (ram_addr, ram_we, ram_wdata) are combinational from the grant.
- Scanout:
  - disp_req is never stalled.
  - disp_valid = 1 exactly one cycle after disp_req, with disp_data = ram_rdata.
  - No other grant occurs in the disp_req cycle.
- Host write:
  - host_ready = host_we && !fifo_full && !clr_busy (registered full flag).
  - An accepted write is pushed into the FIFO.
  - The FIFO drains one entry per granted cycle, in order.
  - Push and pop in the same cycle are allowed.
- Host read:
  - host_ready = !host_we && fifo_empty && !clr_busy && !disp_req. The FIFO-empty condition gives read-after-write ordering.
  - An accepted read drives ram_addr = host_addr, ram_we = 0.
  - host_rvalid = 1 the next cycle with host_rdata = ram_rdata.
  - Reads are not pipelined beyond one outstanding.
- Fill FSM:
  - IDLE -> FILL on clr_start when fifo_empty. clr_start is ignored when the FIFO is not empty or the FSM is in FILL.
  - In FILL, each granted cycle writes clr_pattern_latched to address cnt, then cnt increments.
  - When the write of cnt = WORDS-1 completes: go to IDLE, cnt returns to 0, clr_busy drops the following cycle.
  - A fill pre-empted by disp_req holds cnt.
  - clr_busy = 1 from the cycle after acceptance until the last write.
- Address width: addresses >= WORDS are passed to the RAM unchecked (host responsibility). Fill never exceeds WORDS-1.
- Scanout rate is at most one request per 80 clk, so fill and FIFO cannot starve. A full fill takes 9216 + (number of disp_req during fill) cycles.

Decomposition:
- Shared package vram_pkg holds:
  - AW, DW, WORDS constants
  - fill-state enum {FILL_IDLE, FILL_RUN}
  - grant enum {G_NONE, G_DISP, G_FILL, G_WR, G_RD}
- One sub-module: vram_wfifo, a FIFO_DEPTH x (AW+DW) synchronous FIFO with push/pop/full/empty. Synchronous active-low reset.

Test Plan:
- Reset then idle -> all outputs 0; a clr_start pulse while rst_n = 0 has no effect.
- disp_req with disp_addr = 0x0010, RAM preloaded with 0xA5A5 -> next cycle disp_valid = 1, disp_data = 0xA5A5.
- Host writes 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 to addresses 0..4 back-to-back, with disp_req asserted on cycles 1 and 2:
  - host_ready stays 1 throughout, because the FIFO drains in free cycles.
  - RAM ends with 0x1111..0x5555 at addresses 0..4, in order.
- Host write 0x00FF to address 5 immediately followed by a read of address 5 -> read stalls (host_ready = 0) until the FIFO is empty, then host_rvalid returns 0x00FF.
- clr_start with clr_pattern = 0x5555 and disp_req every 80 clk:
  - clr_busy stays high for 9216 + number-of-disp_req cycles.
  - All words read back 0x5555.
  - Host writes are refused during the fill.
- rst_n low at cnt = 100 mid-fill -> clr_busy = 0 next cycle; words 0..99 = pattern, word 100 onward unchanged.
